// File: rtl/router_pkg.sv
// Shared constants and FSM state type for the router buffer loader.
// An assignment word is [0:4]: bit 0 = "no message", bits [1:4] = source cell.
package router_pkg;

  localparam logic [0:4] NO_MSG       = 5'b10000;
  localparam int         NUM_CELLS    = 16;
  localparam int         NUM_BUFS     = 4;
  localparam int         DEF_MSG_BITS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic res_active(input logic [0:4] r);
    return ~r[0];
  endfunction

endpackage

// File: rtl/buffer_lane.sv
// One message buffer: latched assignment, serial capture from the assigned cell,
// source index and valid/ack handshake.
module buffer_lane
  import router_pkg::*;
#(
  parameter int MSG_BITS = DEF_MSG_BITS,
  parameter int CW       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  latch,
  input  logic [0:4]            res,
  input  logic                  load,
  input  logic                  load_last,
  input  logic [CW-1:0]         bit_idx,
  input  logic [0:NUM_CELLS-1]  cell_data,
  input  logic                  ack,
  output logic [0:MSG_BITS-1]   msg_data,
  output logic [3:0]            src,
  output logic                  valid,
  output logic [0:NUM_CELLS-1]  sel
);

  logic [0:4] res_q;
  logic       active;
  logic [3:0] idx;

  assign active = res_active(res_q);
  assign idx    = res_q[1:4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q    <= NO_MSG;
      msg_data <= '0;
      src      <= '0;
      valid    <= 1'b0;
    end else begin
      if (latch) res_q <= res;
      if (load && active) begin
        msg_data[bit_idx] <= cell_data[idx];
        if (load_last) begin
          src   <= idx;
          valid <= 1'b1;
        end
      end else if (ack && valid) begin
        valid <= 1'b0;
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      sel[i] = active && (idx == 4'(i));
    end
  end

endmodule

// File: rtl/buffer_loader.sv
// Loads up to four serial messages from granted cells into buffers, then holds
// them until each is acknowledged downstream.
//
// state | meaning
// IDLE  | waiting for a start with at least one active assignment
// LOAD  | cells granted, one message bit captured per cycle
// HOLD  | buffers valid, waiting for acknowledges
module buffer_loader
  import router_pkg::*;
#(
  parameter int MSG_BITS = DEF_MSG_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [0:4]            res1,
  input  logic [0:4]            res2,
  input  logic [0:4]            res3,
  input  logic [0:4]            res4,
  input  logic [0:NUM_CELLS-1]  cellData,
  output logic [0:NUM_CELLS-1]  grant,
  output logic [0:MSG_BITS-1]   buf1,
  output logic [0:MSG_BITS-1]   buf2,
  output logic [0:MSG_BITS-1]   buf3,
  output logic [0:MSG_BITS-1]   buf4,
  output logic [3:0]            src1,
  output logic [3:0]            src2,
  output logic [3:0]            src3,
  output logic [3:0]            src4,
  output logic [0:NUM_BUFS-1]   bufValid,
  input  logic [0:NUM_BUFS-1]   bufAck,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int CW = (MSG_BITS > 1) ? $clog2(MSG_BITS) : 1;

  state_t               state_q, state_d;
  logic [CW-1:0]        bit_cnt;
  logic                 accept, load_last, done_d, any_req;
  logic [0:4]           res_in   [NUM_BUFS];
  logic [0:MSG_BITS-1]  lane_data[NUM_BUFS];
  logic [3:0]           lane_src [NUM_BUFS];
  logic [0:NUM_CELLS-1] lane_sel [NUM_BUFS];

  assign res_in[0] = res1;
  assign res_in[1] = res2;
  assign res_in[2] = res3;
  assign res_in[3] = res4;

  assign any_req   = res_active(res1) | res_active(res2) | res_active(res3) | res_active(res4);
  assign load_last = (state_q == LOAD) && (bit_cnt == CW'(MSG_BITS - 1));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start && any_req) begin
        accept  = 1'b1;
        state_d = LOAD;
      end
      LOAD: if (load_last) state_d = HOLD;
      HOLD: if ((bufValid & ~bufAck) == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_cnt <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (start && (state_q != IDLE)) overrun <= 1'b1;
      if (state_q == LOAD && !load_last) bit_cnt <= bit_cnt + 1'b1;
      else                               bit_cnt <= '0;
    end
  end

  for (genvar n = 0; n < NUM_BUFS; n++) begin : g_lane
    buffer_lane #(.MSG_BITS(MSG_BITS), .CW(CW)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .latch     (accept),
      .res       (res_in[n]),
      .load      (state_q == LOAD),
      .load_last (load_last),
      .bit_idx   (bit_cnt),
      .cell_data (cellData),
      .ack       (bufAck[n]),
      .msg_data  (lane_data[n]),
      .src       (lane_src[n]),
      .valid     (bufValid[n]),
      .sel       (lane_sel[n])
    );
  end

  // A cell named by several lanes still gets a single grant bit.
  always_comb begin
    grant = '0;
    if (state_q == LOAD) begin
      for (int n = 0; n < NUM_BUFS; n++) grant = grant | lane_sel[n];
    end
  end

  assign busy = (state_q != IDLE);
  assign buf1 = lane_data[0];
  assign buf2 = lane_data[1];
  assign buf3 = lane_data[2];
  assign buf4 = lane_data[3];
  assign src1 = lane_src[0];
  assign src2 = lane_src[1];
  assign src3 = lane_src[2];
  assign src4 = lane_src[3];

endmodule
